// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, state encoding and decode helpers for the fetch/execute sequencer.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_MFHI = 5'b11001;
    localparam logic [4:0] OP_MFLO = 5'b11010;
    localparam logic [4:0] OP_NOP  = 5'b11011;
    localparam logic [4:0] OP_HALT = 5'b11100;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH0 = 3'd1,
        FETCH1 = 3'd2,
        FETCH2 = 3'd3,
        EXEC3  = 3'd4,
        EXEC4  = 3'd5,
        EXEC5  = 3'd6,
        HALTED = 3'd7
    } state_t;

    // R-format ALU ops take the three-step execute path.
    function automatic logic is_alu(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/fetch_exec_control_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface fetch_exec_control_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      IR;
    logic             Stop;
    logic             PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout;
    logic             MARin, MDRin, IRin, Yin, Zin, PCin, Rin;
    logic             GRA, GRB, GRC, Rout, BAout;
    logic             IncPC, Read, Write;
    logic [4:0]       operation;
    logic             Run;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  IR, Stop,
        output PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout,
        output MARin, MDRin, IRin, Yin, Zin, PCin, Rin,
        output GRA, GRB, GRC, Rout, BAout,
        output IncPC, Read, Write, operation, Run, instr_count
    );

    modport slave (
        output IR, Stop,
        input  PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout,
        input  MARin, MDRin, IRin, Yin, Zin, PCin, Rin,
        input  GRA, GRB, GRC, Rout, BAout,
        input  IncPC, Read, Write, operation, Run, instr_count
    );
endinterface

// File: rtl/fetch_exec_control.sv
// Moore fetch/execute sequencer: drives datapath strobes, counts retired instructions.
module fetch_exec_control
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input logic                  Clock,
    input logic                  Reset,
    fetch_exec_control_if.master bus
);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [4:0]       opcode;

    assign opcode          = bus.IR[31:27];
    assign bus.instr_count = count;

    // State sequencing and retire counting; Stop only matters on the retire edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            unique case (state)
                IDLE:   state <= FETCH0;
                FETCH0: state <= FETCH1;
                FETCH1: state <= FETCH2;
                FETCH2: state <= EXEC3;
                EXEC3: begin
                    if (is_alu(opcode)) begin
                        state <= EXEC4;
                    end else if (opcode == OP_HALT) begin
                        // halt is not counted as retired
                        state <= HALTED;
                    end else begin
                        count <= count + 1'b1;
                        state <= bus.Stop ? HALTED : FETCH0;
                    end
                end
                EXEC4:  state <= EXEC5;
                EXEC5: begin
                    count <= count + 1'b1;
                    state <= bus.Stop ? HALTED : FETCH0;
                end
                HALTED: state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobe decode from state (and opcode in execute states only).
    always_comb begin
        bus.PCout     = 1'b0;
        bus.Zlowout   = 1'b0;
        bus.ZHighout  = 1'b0;
        bus.MDRout    = 1'b0;
        bus.HIout     = 1'b0;
        bus.LOout     = 1'b0;
        bus.Cout      = 1'b0;
        bus.InPortout = 1'b0;
        bus.MARin     = 1'b0;
        bus.MDRin     = 1'b0;
        bus.IRin      = 1'b0;
        bus.Yin       = 1'b0;
        bus.Zin       = 1'b0;
        bus.PCin      = 1'b0;
        bus.Rin       = 1'b0;
        bus.GRA       = 1'b0;
        bus.GRB       = 1'b0;
        bus.GRC       = 1'b0;
        bus.Rout      = 1'b0;
        bus.BAout     = 1'b0;
        bus.IncPC     = 1'b0;
        bus.Read      = 1'b0;
        bus.Write     = 1'b0;
        bus.operation = 5'b00000;
        bus.Run       = (state != IDLE) && (state != HALTED);
        unique case (state)
            FETCH0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            FETCH1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            FETCH2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            EXEC3: begin
                if (is_alu(opcode)) begin
                    bus.GRB  = 1'b1;
                    bus.Rout = 1'b1;
                    bus.Yin  = 1'b1;
                end else if (opcode == OP_MFHI) begin
                    bus.GRA   = 1'b1;
                    bus.Rin   = 1'b1;
                    bus.HIout = 1'b1;
                end else if (opcode == OP_MFLO) begin
                    bus.GRA   = 1'b1;
                    bus.Rin   = 1'b1;
                    bus.LOout = 1'b1;
                end
            end
            EXEC4: begin
                bus.GRC       = 1'b1;
                bus.Rout      = 1'b1;
                bus.Zin       = 1'b1;
                bus.operation = opcode;
            end
            EXEC5: begin
                bus.Zlowout = 1'b1;
                bus.GRA     = 1'b1;
                bus.Rin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_exec_control.sv
// Randomized self-checking bench: per-cycle strobe expectations built from the instruction table.
module tb_fetch_exec_control;
    import cpu_ctrl_pkg::*;

    localparam int unsigned CNT_W = 4;

    // Strobe bit positions in the packed observation vector.
    localparam logic [22:0] S_PCOUT = 23'd1 << 0;
    localparam logic [22:0] S_ZLOW  = 23'd1 << 1;
    localparam logic [22:0] S_MDROUT = 23'd1 << 3;
    localparam logic [22:0] S_HIOUT = 23'd1 << 4;
    localparam logic [22:0] S_LOOUT = 23'd1 << 5;
    localparam logic [22:0] S_MARIN = 23'd1 << 8;
    localparam logic [22:0] S_MDRIN = 23'd1 << 9;
    localparam logic [22:0] S_IRIN  = 23'd1 << 10;
    localparam logic [22:0] S_YIN   = 23'd1 << 11;
    localparam logic [22:0] S_ZIN   = 23'd1 << 12;
    localparam logic [22:0] S_PCIN  = 23'd1 << 13;
    localparam logic [22:0] S_RIN   = 23'd1 << 14;
    localparam logic [22:0] S_GRA   = 23'd1 << 15;
    localparam logic [22:0] S_GRB   = 23'd1 << 16;
    localparam logic [22:0] S_GRC   = 23'd1 << 17;
    localparam logic [22:0] S_ROUT  = 23'd1 << 18;
    localparam logic [22:0] S_INCPC = 23'd1 << 20;
    localparam logic [22:0] S_READ  = 23'd1 << 21;

    logic Clock;
    logic Reset;
    fetch_exec_control_if #(.CNT_W(CNT_W)) bus ();

    fetch_exec_control #(.CNT_W(CNT_W)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    logic [22:0] strobes;
    assign strobes = {bus.Write, bus.Read, bus.IncPC, bus.BAout, bus.Rout, bus.GRC, bus.GRB,
                      bus.GRA, bus.Rin, bus.PCin, bus.Zin, bus.Yin, bus.IRin, bus.MDRin,
                      bus.MARin, bus.InPortout, bus.Cout, bus.LOout, bus.HIout, bus.MDRout,
                      bus.ZHighout, bus.Zlowout, bus.PCout};

    int n_tests = 0;
    int n_fail  = 0;
    int model_cnt = 0;
    bit model_halted = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, " strobes"}, 32'(strobes), 32'd0);
        check_eq({tag, " op"}, 32'(bus.operation), 32'd0);
        check_eq({tag, " run"}, 32'(bus.Run), 32'd0);
        check_eq({tag, " cnt"}, 32'(bus.instr_count), 32'(model_cnt));
    endtask

    // Called with Reset already high: drop it, check the single dead cycle, land in FETCH0.
    task automatic release_reset();
        step();
        Reset = 1'b0;
        check_quiet("idle");
        step();
        model_halted = 0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        model_cnt = 0;
        #1;
        check_quiet("async_rst");
        release_reset();
    endtask

    // mode: 0 no Stop, 1 one-cycle Stop before retire, 2 Stop held into retire, 3 reset in EXEC4
    task automatic run_instr(input logic [4:0] op, input int mode);
        logic [22:0] exp_s[$];
        logic [4:0]  exp_o[$];
        int n;
        int stop_k;
        exp_s.push_back(S_PCOUT | S_MARIN | S_INCPC | S_ZIN);  exp_o.push_back(5'd0);
        exp_s.push_back(S_ZLOW | S_PCIN | S_READ | S_MDRIN);   exp_o.push_back(5'd0);
        exp_s.push_back(S_MDROUT | S_IRIN);                    exp_o.push_back(5'd0);
        if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR}) begin
            exp_s.push_back(S_GRB | S_ROUT | S_YIN);            exp_o.push_back(5'd0);
            exp_s.push_back(S_GRC | S_ROUT | S_ZIN);            exp_o.push_back(op);
            exp_s.push_back(S_ZLOW | S_GRA | S_RIN);            exp_o.push_back(5'd0);
        end else if (op == OP_MFHI) begin
            exp_s.push_back(S_GRA | S_RIN | S_HIOUT);           exp_o.push_back(5'd0);
        end else if (op == OP_MFLO) begin
            exp_s.push_back(S_GRA | S_RIN | S_LOOUT);           exp_o.push_back(5'd0);
        end else begin
            exp_s.push_back(23'd0);                             exp_o.push_back(5'd0);
        end
        n = exp_s.size();
        stop_k = (mode == 1) ? int'($urandom_range(0, n - 2)) : -1;
        for (int k = 0; k < n; k++) begin
            string t;
            t = $sformatf("op%0h k%0d", op, k);
            check_eq({t, " strobes"}, 32'(strobes), 32'(exp_s[k]));
            check_eq({t, " op"}, 32'(bus.operation), 32'(exp_o[k]));
            check_eq({t, " run"}, 32'(bus.Run), 32'd1);
            check_eq({t, " cnt"}, 32'(bus.instr_count), 32'(model_cnt));
            if (k == 2) bus.IR = {op, 27'($urandom)};
            bus.Stop = (mode == 1 && k == stop_k) || (mode == 2 && k >= n - 2);
            if (mode == 3 && k == 4) begin
                #2;
                Reset = 1'b1;
                model_cnt = 0;
                #1;
                check_quiet("mid_rst");
                bus.Stop = 1'b0;
                return;
            end
            step();
        end
        bus.Stop = 1'b0;
        if (op != OP_HALT) model_cnt = (model_cnt + 1) % (1 << CNT_W);
        model_halted = (op == OP_HALT) || (mode == 2);
    endtask

    task automatic hold_halted(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            check_quiet($sformatf("halted c%0d", i));
            bus.Stop = 1'($urandom_range(0, 1));
            bus.IR = {OP_ADD, 27'd0};
            step();
        end
        bus.Stop = 1'b0;
    endtask

    logic [4:0] pool [8];

    initial begin
        pool[0] = OP_ADD;  pool[1] = OP_SUB;  pool[2] = OP_AND;  pool[3] = OP_OR;
        pool[4] = OP_MFHI; pool[5] = OP_MFLO; pool[6] = OP_NOP;  pool[7] = 5'b01010;
        Reset = 1'b1;
        bus.IR = '0;
        bus.Stop = 1'b0;
        #12;
        @(posedge Clock);
        #1;
        check_quiet("reset");
        release_reset();

        run_instr(OP_ADD, 0);
        run_instr(OP_MFHI, 0);
        run_instr(OP_MFLO, 1);
        run_instr(OP_NOP, 1);
        run_instr(OP_SUB, 0);
        run_instr(OP_AND, 1);
        run_instr(OP_OR, 0);
        run_instr(5'b01010, 0);
        // Long random stream carries the 4-bit counter across its wrap.
        for (int i = 0; i < 30; i++) begin
            run_instr(pool[$urandom_range(0, 7)], int'($urandom_range(0, 1)));
        end
        check_eq("halted_flag_before", 32'(model_halted), 32'd0);

        run_instr(OP_ADD, 2);
        hold_halted(10);

        do_reset();
        run_instr(OP_HALT, 0);
        hold_halted(10);

        do_reset();
        run_instr(OP_NOP, 0);
        run_instr(OP_MFHI, 0);
        run_instr(OP_ADD, 3);
        release_reset();
        run_instr(OP_MFLO, 0);
        check_eq("post_rst cnt", 32'(bus.instr_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
